// File: rtl/qos_pkg.sv
// qos_pkg: shared state encoding and default sizing for the QoS selector.
// The state_t value is driven straight onto state_o.
package qos_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMER_W = 20;
  localparam int STATE_W     = 3;
  localparam int STATS_W     = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    AUTO   = 3'd2,
    SCAN   = 3'd3,
    COMMIT = 3'd4,
    MANUAL = 3'd5
  } state_t;

endpackage

// File: rtl/qos_best_scan.sv
// qos_best_scan: running best-channel tracker, one priority entry per step.
// Out-of-range or invalid candidates never update the best.
module qos_best_scan
  import qos_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CH_W  = $clog2(DEF_N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    step,
  input  logic [CH_W-1:0]         cand,
  input  logic [CH_W-1:0]         cur_sel,
  input  logic                    fallback_en,
  input  logic [N_CH-1:0]         snap_valid,
  input  logic [N_CH*CNT_W-1:0]   snap_err,
  output logic                    found,
  output logic [CH_W-1:0]         best_ch,
  output logic [CNT_W-1:0]        best_err
);

  logic             cand_ok;
  logic [CNT_W-1:0] cand_err;
  logic             take;

  always_comb begin
    cand_ok  = 1'b0;
    cand_err = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cand == CH_W'(i)) begin
        cand_ok  = snap_valid[i];
        cand_err = snap_err[i*CNT_W +: CNT_W];
      end
    end
  end

  // Equal error keeps the current channel only when fallback is off.
  always_comb begin
    take = 1'b0;
    if (step && cand_ok) begin
      take = !found
          || (cand_err < best_err)
          || (!fallback_en
              && (cand == cur_sel)
              && (cand_err == best_err));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found    <= 1'b0;
      best_ch  <= '0;
      best_err <= '0;
    end else if (clear) begin
      found    <= 1'b0;
      best_ch  <= '0;
      best_err <= '0;
    end else if (take) begin
      found    <= 1'b1;
      best_ch  <= cand;
      best_err <= cand_err;
    end
  end

endmodule

// File: rtl/qos_channel_selector.sv
// qos_channel_selector: N-channel TS source selector with timed priority scan.
// Define QOS_SEL_STATS_EN to add the saturating switch_count output.
module qos_channel_selector
  import qos_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMER_W = DEF_TIMER_W,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       valid,
  input  logic [N_CH*CNT_W-1:0] err_count,
  input  logic                  cfg_valid,
  input  logic                  cfg_manual_en,
  input  logic [CH_W-1:0]       cfg_manual_ch,
  input  logic [N_CH*CH_W-1:0]  cfg_priority,
  input  logic [TIMER_W-1:0]    cfg_period,
  input  logic                  cfg_fallback_en,
  input  logic [CNT_W-1:0]      cfg_hyst,
  output logic [CH_W-1:0]       mux_sel,
  output logic                  mux_en,
  output logic [TIMER_W-1:0]    timer,
  output logic                  no_signal,
  output logic                  switch_pulse,
`ifdef QOS_SEL_STATS_EN
  output logic [STATS_W-1:0]    switch_count,
`endif
  output logic [STATE_W-1:0]    state_o
);

  localparam logic [CH_W-1:0] LAST_K = CH_W'(N_CH - 1);

  state_t                state;

  logic                  sh_manual_en;
  logic [CH_W-1:0]       sh_manual_ch;
  logic [N_CH*CH_W-1:0]  sh_prio;
  logic [TIMER_W-1:0]    sh_period;
  logic                  sh_fb;
  logic [CNT_W-1:0]      sh_hyst;

  logic [N_CH-1:0]       snap_valid;
  logic [N_CH*CNT_W-1:0] snap_err;

  logic [CH_W-1:0]       scan_k;
  logic [CH_W-1:0]       cand;
  logic                  found;
  logic [CH_W-1:0]       best_ch;
  logic [CNT_W-1:0]      best_err;

  logic                  cur_ok;
  logic [CNT_W-1:0]      cur_err;
  logic                  live_ok;
  logic                  timer_hit;
  logic                  scan_clear;
  logic                  scan_step;
  logic                  do_switch;

  assign cand = sh_prio[int'(scan_k)*CH_W +: CH_W];

  assign timer_hit = (sh_period != '0)
                  && (timer == sh_period - TIMER_W'(1));

  assign scan_clear = (state == AUTO) && timer_hit && !cfg_valid;
  assign scan_step  = (state == SCAN) && !cfg_valid;

  qos_best_scan #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .CH_W  (CH_W)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (scan_clear),
    .step        (scan_step),
    .cand        (cand),
    .cur_sel     (mux_sel),
    .fallback_en (sh_fb),
    .snap_valid  (snap_valid),
    .snap_err    (snap_err),
    .found       (found),
    .best_ch     (best_ch),
    .best_err    (best_err)
  );

  // Current channel against the snapshot (commit) and live inputs.
  always_comb begin
    cur_ok  = 1'b0;
    cur_err = '0;
    live_ok = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (mux_sel == CH_W'(i)) begin
        cur_ok  = snap_valid[i];
        cur_err = snap_err[i*CNT_W +: CNT_W];
        live_ok = valid[i];
      end
    end
  end

  // Hysteresis sum is one bit wider so it cannot wrap.
  assign do_switch = found
                  && (best_ch != mux_sel)
                  && (!cur_ok
                      || (({1'b0, best_err} + {1'b0, sh_hyst})
                          <= {1'b0, cur_err}));

  assign no_signal = mux_en & ~live_ok;
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mux_sel      <= '0;
      mux_en       <= 1'b0;
      timer        <= '0;
      switch_pulse <= 1'b0;
      scan_k       <= '0;
      sh_manual_en <= 1'b0;
      sh_manual_ch <= '0;
      sh_prio      <= '0;
      sh_period    <= '0;
      sh_fb        <= 1'b0;
      sh_hyst      <= '0;
      snap_valid   <= '0;
      snap_err     <= '0;
    end else begin
      switch_pulse <= 1'b0;
      if (cfg_valid) begin
        state        <= CONFIG;
        timer        <= '0;
        sh_manual_en <= cfg_manual_en;
        sh_manual_ch <= cfg_manual_ch;
        sh_prio      <= cfg_priority;
        sh_period    <= cfg_period;
        sh_fb        <= cfg_fallback_en;
        sh_hyst      <= cfg_hyst;
      end else begin
        unique case (state)
          IDLE: begin
            state <= IDLE;
          end
          CONFIG: begin
            mux_en <= 1'b1;
            timer  <= '0;
            if (sh_manual_en) begin
              mux_sel <= sh_manual_ch;
              state   <= MANUAL;
            end else begin
              mux_sel <= sh_prio[CH_W-1:0];
              state   <= AUTO;
            end
          end
          AUTO: begin
            if (sh_period == '0) begin
              timer <= '0;
            end else if (timer_hit) begin
              snap_valid <= valid;
              snap_err   <= err_count;
              scan_k     <= '0;
              state      <= SCAN;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          SCAN: begin
            if (scan_k == LAST_K) begin
              state <= COMMIT;
            end else begin
              scan_k <= scan_k + CH_W'(1);
            end
          end
          COMMIT: begin
            if (do_switch) begin
              mux_sel      <= best_ch;
              switch_pulse <= 1'b1;
            end
            timer <= '0;
            state <= AUTO;
          end
          MANUAL: begin
            state <= MANUAL;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef QOS_SEL_STATS_EN
  logic [STATS_W-1:0] sw_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt <= '0;
    end else if (!cfg_valid && state == CONFIG) begin
      sw_cnt <= '0;
    end else if (!cfg_valid && state == COMMIT
                 && do_switch && sw_cnt != '1) begin
      sw_cnt <= sw_cnt + STATS_W'(1);
    end
  end

  assign switch_count = sw_cnt;
`endif

endmodule

// File: tb/tb_qos_channel_selector.sv
// tb_qos_channel_selector: directed scoreboard bench for the QoS selector.
// Stimulus queues timed expectations; a negedge monitor checks them.
module tb_qos_channel_selector;
  import qos_pkg::*;

  localparam int K_SEL   = 0;
  localparam int K_EN    = 1;
  localparam int K_TIMER = 2;
  localparam int K_NOSIG = 3;
  localparam int K_PULSE = 4;
  localparam int K_STATE = 5;
  localparam int K_TMR8  = 6;
  localparam int K_ST8   = 7;
  localparam int K_CNT   = 8;
  localparam int K_SW    = 9;
  localparam int K_SEL8  = 10;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] err_count;
  logic        cfg_valid;
  logic        cfg_manual_en;
  logic [1:0]  cfg_manual_ch;
  logic [7:0]  cfg_priority;
  logic [19:0] cfg_period;
  logic        cfg_fallback_en;
  logic [7:0]  cfg_hyst;
  logic [1:0]  mux_sel;
  logic        mux_en;
  logic [19:0] timer;
  logic        no_signal;
  logic        switch_pulse;
  logic [2:0]  state_o;
`ifdef QOS_SEL_STATS_EN
  logic [15:0] switch_count;
`endif

  logic [7:0]  valid8;
  logic [63:0] err8;
  logic        cfg_valid8;
  logic [23:0] prio8;
  logic [2:0]  mux_sel8;
  logic        mux_en8;
  logic [19:0] timer8;
  logic        no_signal8;
  logic        pulse8;
  logic [2:0]  state8;
`ifdef QOS_SEL_STATS_EN
  logic [15:0] switch_count8;
`endif

  qos_channel_selector #(.N_CH(4), .CNT_W(8), .TIMER_W(20)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid           (valid),
    .err_count       (err_count),
    .cfg_valid       (cfg_valid),
    .cfg_manual_en   (cfg_manual_en),
    .cfg_manual_ch   (cfg_manual_ch),
    .cfg_priority    (cfg_priority),
    .cfg_period      (cfg_period),
    .cfg_fallback_en (cfg_fallback_en),
    .cfg_hyst        (cfg_hyst),
    .mux_sel         (mux_sel),
    .mux_en          (mux_en),
    .timer           (timer),
    .no_signal       (no_signal),
    .switch_pulse    (switch_pulse),
`ifdef QOS_SEL_STATS_EN
    .switch_count    (switch_count),
`endif
    .state_o         (state_o)
  );

  qos_channel_selector #(.N_CH(8), .CNT_W(8), .TIMER_W(20)) dut8 (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid           (valid8),
    .err_count       (err8),
    .cfg_valid       (cfg_valid8),
    .cfg_manual_en   (1'b0),
    .cfg_manual_ch   (3'd0),
    .cfg_priority    (prio8),
    .cfg_period      (20'd0),
    .cfg_fallback_en (1'b1),
    .cfg_hyst        (8'd0),
    .mux_sel         (mux_sel8),
    .mux_en          (mux_en8),
    .timer           (timer8),
    .no_signal       (no_signal8),
    .switch_pulse    (pulse8),
`ifdef QOS_SEL_STATS_EN
    .switch_count    (switch_count8),
`endif
    .state_o         (state8)
  );

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_SEL:   return "mux_sel";
      K_EN:    return "mux_en";
      K_TIMER: return "timer";
      K_NOSIG: return "no_signal";
      K_PULSE: return "switch_pulse";
      K_STATE: return "state_o";
      K_TMR8:  return "timer_n8";
      K_ST8:   return "state_n8";
      K_CNT:   return "switch_count";
      K_SW:    return "switch_event";
      K_SEL8:  return "mux_sel_n8";
      default: return "unknown";
    endcase
  endfunction

  function automatic int actual(input int k);
    case (k)
      K_SEL:   return int'(mux_sel);
      K_EN:    return int'(mux_en);
      K_TIMER: return int'(timer);
      K_NOSIG: return int'(no_signal);
      K_PULSE: return int'(switch_pulse);
      K_STATE: return int'(state_o);
      K_TMR8:  return int'(timer8);
      K_ST8:   return int'(state8);
`ifdef QOS_SEL_STATS_EN
      K_CNT:   return int'(switch_count);
`endif
      K_SW:    return switch_pulse ? int'(mux_sel) : -1;
      K_SEL8:  return int'(mux_sel8);
      default: return -2;
    endcase
  endfunction

  task automatic expect_at(input int c, input int k, input int v);
    q.push_back('{cyc: c, kind: k, val: v});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] errs(input int e0, input int e1,
                                       input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic do_cfg(input logic man, input logic [1:0] mch,
                        input logic [7:0] prio, input logic [19:0] per,
                        input logic fb, input logic [7:0] hy,
                        output int c);
    c = cyc + 1;
    expect_at(c, K_STATE, int'(CONFIG));
    cfg_valid       = 1'b1;
    cfg_manual_en   = man;
    cfg_manual_ch   = mch;
    cfg_priority    = prio;
    cfg_period      = per;
    cfg_fallback_en = fb;
    cfg_hyst        = hy;
    @(negedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    bit ev_seen;
    int act;
    ev_seen = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc < cyc) begin
        checks++;
        fails++;
        $display("FAIL stale_%s cyc=%0d due=%0d", kname(q[i].kind),
                 cyc, q[i].cyc);
        q.delete(i);
      end else if (q[i].cyc == cyc) begin
        act = actual(q[i].kind);
        if (q[i].kind == K_SW) ev_seen = 1'b1;
        checks++;
        if (act != q[i].val) begin
          fails++;
          $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                   kname(q[i].kind), cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
    if (switch_pulse && !ev_seen) begin
      checks++;
      fails++;
      $display("FAIL unexpected_switch cyc=%0d actual_sel=%0d required=none",
               cyc, mux_sel);
    end
    if (state8 == SCAN || pulse8) begin
      checks++;
      fails++;
      $display("FAIL n8_scan cyc=%0d actual_state=%0d pulse=%0d required=no scan",
               cyc, state8, pulse8);
    end
    if (done || cyc > 3000) begin
      checks++;
      if (!done || q.size() != 0) begin
        fails++;
        $display("FAIL end_state cyc=%0d actual_pending=%0d required=0 done=%0d",
                 cyc, q.size(), done);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
    end
  end

  initial begin
    int c0;
    int c1;
    int c8;
    rst_n           = 1'b0;
    valid           = '0;
    err_count       = '0;
    cfg_valid       = 1'b0;
    cfg_manual_en   = 1'b0;
    cfg_manual_ch   = '0;
    cfg_priority    = '0;
    cfg_period      = '0;
    cfg_fallback_en = 1'b0;
    cfg_hyst        = '0;
    valid8          = '0;
    err8            = '0;
    cfg_valid8      = 1'b0;
    prio8           = '0;

    expect_at(2, K_SEL, 0);
    expect_at(2, K_EN, 0);
    expect_at(2, K_TIMER, 0);
    expect_at(2, K_NOSIG, 0);
    expect_at(2, K_PULSE, 0);
    expect_at(2, K_STATE, int'(IDLE));
    wait_until(3);
    rst_n = 1'b1;
    expect_at(5, K_STATE, int'(IDLE));
    expect_at(5, K_EN, 0);
    wait_until(5);

    // N_CH=8, period 0: channel 5 is best but no scan may ever run.
    c8 = cyc + 1;
    expect_at(c8, K_ST8, int'(CONFIG));
    expect_at(c8 + 1, K_ST8, int'(AUTO));
    expect_at(c8 + 5, K_TMR8, 0);
    expect_at(c8 + 60, K_ST8, int'(AUTO));
    expect_at(c8 + 60, K_TMR8, 0);
    expect_at(c8 + 60, K_SEL8, 0);
    valid8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      prio8[i*3 +: 3] = 3'(i);
      err8[i*8 +: 8]  = (i == 5) ? 8'd1 : 8'd9;
    end
    cfg_valid8 = 1'b1;
    @(negedge clk);
    #1;
    cfg_valid8 = 1'b0;

    // Fallback on: tie 1 vs 2 resolves to 1, then stays.
    valid     = 4'hF;
    err_count = errs(5, 3, 3, 9);
    do_cfg(1'b0, 2'd0, 8'b11100100, 20'd10, 1'b1, 8'd0, c0);
    expect_at(c0 + 1, K_SEL, 0);
    expect_at(c0 + 1, K_EN, 1);
    expect_at(c0 + 1, K_STATE, int'(AUTO));
    expect_at(c0 + 1, K_TIMER, 0);
    expect_at(c0 + 10, K_TIMER, 9);
    expect_at(c0 + 11, K_STATE, int'(SCAN));
    expect_at(c0 + 15, K_STATE, int'(COMMIT));
    expect_at(c0 + 16, K_SW, 1);
    expect_at(c0 + 16, K_TIMER, 0);
    expect_at(c0 + 17, K_PULSE, 0);
    expect_at(c0 + 33, K_SEL, 1);
    wait_until(c0 + 34);

    // Fallback off: current channel 2 keeps the tie.
    err_count = errs(5, 9, 3, 9);
    do_cfg(1'b0, 2'd0, 8'b11100100, 20'd10, 1'b0, 8'd0, c0);
    expect_at(c0 + 16, K_SW, 2);
    expect_at(c0 + 31, K_PULSE, 0);
    expect_at(c0 + 32, K_SEL, 2);
    wait_until(c0 + 17);
    err_count = errs(5, 3, 3, 9);
    wait_until(c0 + 34);

    // Hysteresis 4: 7 vs 10 holds, 6 vs 10 switches.
    valid     = 4'b0011;
    err_count = errs(10, 7, 0, 0);
    do_cfg(1'b0, 2'd0, 8'b11100100, 20'd10, 1'b1, 8'd4, c0);
    expect_at(c0 + 1, K_NOSIG, 0);
    expect_at(c0 + 17, K_SEL, 0);
    expect_at(c0 + 31, K_SW, 1);
    wait_until(c0 + 17);
    err_count = errs(10, 6, 0, 0);
    wait_until(c0 + 33);

    // Only ch2 present; then nothing present.
    valid     = 4'b0100;
    err_count = errs(0, 0, 50, 0);
    do_cfg(1'b0, 2'd0, 8'b11100100, 20'd10, 1'b1, 8'd0, c0);
    expect_at(c0 + 1, K_NOSIG, 1);
    expect_at(c0 + 16, K_SW, 2);
    expect_at(c0 + 17, K_NOSIG, 0);
    expect_at(c0 + 18, K_NOSIG, 1);
    expect_at(c0 + 33, K_SEL, 2);
    expect_at(c0 + 33, K_NOSIG, 1);
    wait_until(c0 + 17);
    valid = 4'b0000;
    wait_until(c0 + 34);

    // Manual ch3 while ch0 has the lowest error.
    valid     = 4'hF;
    err_count = errs(0, 50, 50, 50);
    do_cfg(1'b1, 2'd3, 8'b11100100, 20'd10, 1'b1, 8'd0, c0);
    expect_at(c0 + 1, K_STATE, int'(MANUAL));
    expect_at(c0 + 1, K_SEL, 3);
    expect_at(c0 + 20, K_TIMER, 0);
    expect_at(c0 + 40, K_SEL, 3);
    expect_at(c0 + 40, K_STATE, int'(MANUAL));
    wait_until(c0 + 41);

    // cfg_valid mid-scan aborts the pending switch to ch0.
    err_count = errs(0, 9, 9, 9);
    do_cfg(1'b0, 2'd0, 8'b00011011, 20'd10, 1'b1, 8'd0, c0);
    expect_at(c0 + 1, K_SEL, 3);
    expect_at(c0 + 12, K_STATE, int'(SCAN));
    wait_until(c0 + 12);
    do_cfg(1'b0, 2'd0, 8'b00011011, 20'd10, 1'b1, 8'd0, c1);
    expect_at(c1 + 1, K_SEL, 3);
    expect_at(c1 + 16, K_SW, 0);
    wait_until(c1 + 17);

    // Reset asserted mid-scan.
    do_cfg(1'b0, 2'd0, 8'b00011011, 20'd10, 1'b1, 8'd0, c0);
    expect_at(c0 + 12, K_STATE, int'(SCAN));
    expect_at(c0 + 12, K_TIMER, 9);
    expect_at(c0 + 13, K_SEL, 0);
    expect_at(c0 + 13, K_EN, 0);
    expect_at(c0 + 13, K_TIMER, 0);
    expect_at(c0 + 13, K_NOSIG, 0);
    expect_at(c0 + 13, K_PULSE, 0);
    expect_at(c0 + 13, K_STATE, int'(IDLE));
    expect_at(c0 + 20, K_STATE, int'(IDLE));
    expect_at(c0 + 20, K_SEL, 0);
    wait_until(c0 + 12);
    rst_n = 1'b0;
    wait_until(c0 + 14);
    rst_n = 1'b1;
    wait_until(c0 + 21);

`ifdef QOS_SEL_STATS_EN
    // Three commits in a row count to three.
    valid     = 4'hF;
    err_count = errs(5, 3, 3, 9);
    do_cfg(1'b0, 2'd0, 8'b11100100, 20'd10, 1'b1, 8'd0, c0);
    expect_at(c0 + 1, K_CNT, 0);
    expect_at(c0 + 16, K_SW, 1);
    expect_at(c0 + 16, K_CNT, 1);
    expect_at(c0 + 31, K_SW, 0);
    expect_at(c0 + 46, K_SW, 1);
    expect_at(c0 + 47, K_CNT, 3);
    wait_until(c0 + 17);
    err_count = errs(1, 3, 3, 9);
    wait_until(c0 + 32);
    err_count = errs(5, 3, 3, 9);
    wait_until(c0 + 48);
`endif

    wait_until(cyc + 2);
    done = 1'b1;
  end

endmodule

// File: doc/qos_channel_selector.md
# qos_channel_selector

Parametrised N-channel transport-stream source selector for the QoS control path. It consumes per-channel signal-present flags and per-channel error counters, and runs a configurable priority list with a periodic re-selection timer. It drives the select and enable of the downstream TS multiplexer. It generalises the 4-channel main controller with:
- arbitrary channel count;
- a sequential priority scan;
- signal-present gating;
- switch hysteresis.

## Interface
Parameters:
- N_CH, 4, number of input channels (2..16)
- CNT_W, 8, width of each error counter
- TIMER_W, 20, width of the re-selection period
- CH_W, $clog2(N_CH), channel index width (derived, not overridable)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- valid  in  N_CH  signal-present per channel, bit i = channel i
- err_count  in  N_CH*CNT_W  error counters, channel i at [i*CNT_W +: CNT_W]
- cfg_valid  in  1  one-cycle strobe: latch new configuration
- cfg_manual_en  in  1  1 = manual mode
- cfg_manual_ch  in  CH_W  channel used in manual mode
- cfg_priority  in  N_CH*CH_W  priority list, entry k at [k*CH_W +: CH_W], entry 0 highest
- cfg_period  in  TIMER_W  re-selection period in cycles; 0 = auto re-selection disabled
- cfg_fallback_en  in  1  ties resolve to higher priority (1) or keep current (0)
- cfg_hyst  in  CNT_W  minimum error advantage required to switch
- mux_sel  out  CH_W  selected channel
- mux_en  out  1  mux enable
- timer  out  TIMER_W  active period; 0 when disabled or in CONFIG
- no_signal  out  1  the selected channel's valid bit is low
- switch_pulse  out  1  one-cycle pulse when mux_sel changes
- state_o  out  3  current FSM state (status readback)

## Operation
States:
- IDLE: wait for cfg_valid.
- CONFIG: latch all cfg_* inputs into shadow registers and set mux_en=1.
  - If manual: mux_sel=cfg_manual_ch, go to MANUAL.
  - Otherwise: mux_sel=priority entry 0, go to AUTO.
- AUTO: the timer counts 0..period-1. At period-1, snapshot err_count and valid into registers and go to SCAN. With period 0, stay in AUTO; the timer holds 0.
- SCAN: visit priority entries k=0..N_CH-1, one per cycle, using the snapshot.
  - A candidate is eligible only if its snapshot valid bit is 1.
  - best is updated if no best exists yet, or cand_err < best_err, or (cfg_fallback_en=0, cand==mux_sel, cand_err==best_err).
  - After entry N_CH-1, go to COMMIT.
- COMMIT: switch if all of the following hold:
  - a best exists;
  - best != mux_sel;
  - the current channel is invalid, or best_err + cfg_hyst <= cur_err. This sum is computed at CNT_W+1 bits, so there is no wrap.

  On switch: mux_sel=best, switch_pulse=1. Then the timer resets to 0 and the FSM returns to AUTO.
- MANUAL: hold mux_sel. No scan.

Rules that apply in all states:
- cfg_valid in any non-IDLE state forces CONFIG on the next cycle. This aborts a SCAN in progress with no commit.
- Duplicate entries in the priority list are legal; they are evaluated twice and the result is unchanged.
- Out-of-range channel indices (≥N_CH) are never eligible.
- No eligible channel → mux_sel is held. no_signal stays high.
- no_signal = ~valid[mux_sel] (live input, not snapshot), gated by mux_en.

## Timing
- Reset values: mux_sel=0, mux_en=0, timer=0, no_signal=0, switch_pulse=0, state_o=IDLE. All internal counters and snapshots are 0.
- cfg_valid at cycle t: CONFIG at t+1, new mux_sel visible at t+2.
- Auto latency: timer==period-1 at cycle t → SCAN occupies t+1..t+N_CH → COMMIT at t+N_CH+1 → mux_sel updated at t+N_CH+2. The next period then starts from timer 0.
- Asserting rst_n low mid-scan returns everything to reset values immediately.

## Configuration
- QOS_SEL_STATS_EN defined:
  - adds output switch_count (16 bits), which increments on every switch_pulse and saturates at 16'hFFFF;
  - cleared by reset and by CONFIG.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Package qos_pkg holds:
  - the state enum (IDLE, CONFIG, AUTO, SCAN, COMMIT, MANUAL);
  - the state_o encoding;
  - default parameter constants.
- Sub-module qos_best_scan holds the per-cycle compare/update of best channel and best_err, plus the tie/eligibility logic. The top level keeps the FSM, timer, snapshot and commit.

## Test plan
- N_CH=4, period=10, priority {0,1,2,3}, hyst=0, fallback=1, all valid, errs {5,3,3,9}: mux_sel goes 0→1 at 4+2 cycles after the timer hits 9; switch_pulse is a single cycle.
- Same setup with fallback=0 and current channel 2, errs {5,3,3,9}: mux_sel stays 2 and there is no pulse.
- hyst=4, current ch0 err 10, ch1 err 7: no switch. Then ch1 err 6: switch to 1 on the next commit.
- valid=4'b0100 with errs {0,0,50,0}: select ch2 despite its higher error. Then valid=0: mux_sel held, no_signal=1.
- Manual: cfg_manual_en=1, ch=3, errs favouring ch0: mux_sel=3 indefinitely. cfg_valid mid-SCAN in auto mode: no commit, CONFIG next cycle.
- N_CH=8, period=0: no scan ever, timer=0. rst_n low mid-SCAN: all outputs return to reset values. With QOS_SEL_STATS_EN, 3 switches → switch_count=3.
